array_multiplier: RTL and testbench

ARRAY_MULTIPLIER -- requirements
Module: array_multiplier

---
 rtl/array_mul_pkg.sv | 24 ++
 rtl/array_multiplier_ctrl.sv | 65 ++++++
 rtl/array_multiplier.sv | 69 ++++++
 tb/tb_array_multiplier.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/array_mul_pkg.sv
// Shared constants, helpers and control state encoding for the sequential
// shift-and-add signed array multiplier.
package array_mul_pkg;

  localparam int unsigned default_width = 16;

  function automatic int unsigned result_width_for(input int unsigned w);
    return 2 * w;
  endfunction

  // Counter must index bit positions 0..w-1 and never collapse to zero bits.
  function automatic int unsigned count_bits(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int unsigned default_result_width = result_width_for(default_width);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/array_multiplier_ctrl.sv
// Control for the multiplier: IDLE/BUSY/DONE sequencing, multiplier bit
// counter and the one-cycle registered ready pulse.
module array_multiplier_ctrl
  import array_mul_pkg::*;
#(
  parameter  int unsigned width = default_width,
  localparam int unsigned cnt_w = count_bits(width)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             load,
  output logic             step,
  output logic             last,
  output logic [cnt_w-1:0] bit_idx,
  output logic             ready
);

  state_t           state_q, state_d;
  logic [cnt_w-1:0] cnt_q;

  assign bit_idx = cnt_q;
  assign last    = (cnt_q == cnt_w'(width - 1));

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ready   <= 1'b0;
    end else begin
      state_q <= state_d;
      ready   <= step && last;
      if (load) begin
        cnt_q <= '0;
      end else if (step) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // NOTE: every output is defaulted first so no path through the case
  // leaves a value unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        step = 1'b1;
        if (last) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/array_multiplier.sv
// Sequential signed multiplier: one multiplier bit per cycle, LSB first, with
// the sign bit's partial product subtracted for an exact two's complement result.
module array_multiplier
  import array_mul_pkg::*;
#(
  parameter int unsigned width        = default_width,
  parameter int unsigned result_width = result_width_for(width)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic signed [width-1:0]        multiplicand,
  input  logic signed [width-1:0]        multiplier,
  input  logic                           start,
  output logic signed [result_width-1:0] product,
  output logic                           ready
);

  localparam int unsigned cnt_w = count_bits(width);

  logic                           load, step, last;
  logic [cnt_w-1:0]               bit_idx;
  logic signed [width-1:0]        a_q;
  logic [width-1:0]               b_q;
  logic signed [result_width-1:0] acc_q, acc_d, addend;

  array_multiplier_ctrl #(.width(width)) u_ctrl (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .load    (load),
    .step    (step),
    .last    (last),
    .bit_idx (bit_idx),
    .ready   (ready)
  );

  // Size cast of a signed operand sign-extends before the arithmetic shift.
  assign addend = result_width'(a_q) <<< bit_idx;

  always_comb begin
    acc_d = acc_q;
    if (b_q[bit_idx]) begin
      acc_d = last ? (acc_q - addend) : (acc_q + addend);
    end
  end

  // NOTE: operand and accumulator registers are reset too, so an aborted
  // operation leaves no stale state behind for the next start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      product <= '0;
    end else begin
      if (load) begin
        a_q   <= multiplicand;
        b_q   <= multiplier;
        acc_q <= '0;
      end else if (step) begin
        acc_q <= acc_d;
      end
      if (step && last) begin
        product <= acc_d;
      end
    end
  end

endmodule

// File: tb/tb_array_multiplier.sv
// Directed bench for array_multiplier: latency, ready width, product values,
// operand isolation, start-while-busy and asynchronous reset abort.
module tb_array_multiplier;

  localparam int W  = 16;
  localparam int RW = 32;

  logic                 clk = 1'b0;
  logic                 reset;
  logic signed [W-1:0]  multiplicand;
  logic signed [W-1:0]  multiplier;
  logic                 start;
  logic signed [RW-1:0] product;
  logic                 ready;

  int tests  = 0;
  int failed = 0;
  logic signed [RW-1:0] prev_product = '0;

  array_multiplier #(.width(W), .result_width(RW)) dut (
    .clk          (clk),
    .reset        (reset),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .start        (start),
    .product      (product),
    .ready        (ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called just after a negedge; launches one op, scrambles the operands
  // after the capture edge, and returns in the first IDLE cycle after DONE.
  task automatic do_op(input string tag, input logic signed [W-1:0] a,
                       input logic signed [W-1:0] b);
    logic signed [RW-1:0] exp_p;
    int lat;
    exp_p        = a * b;
    multiplicand = a;
    multiplier   = b;
    start        = 1'b1;
    @(posedge clk);
    #1;
    start        = 1'b0;
    multiplicand = W'($urandom);
    multiplier   = W'($urandom);
    lat = -1;
    for (int k = 0; k <= 40; k++) begin
      @(negedge clk);
      if (k == 0 || k == W - 1) check({tag, "_hold"}, product, prev_product);
      if (ready) begin
        lat = k;
        break;
      end
    end
    check({tag, "_latency"}, lat, W);
    check({tag, "_product"}, product, exp_p);
    @(negedge clk);
    check({tag, "_ready_fall"}, ready, 1'b0);
    prev_product = exp_p;
  endtask

  initial begin
    int pulses;
    logic signed [W-1:0] ra, rb;

    reset        = 1'b0;
    start        = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    #2;
    check("reset_product", product, 0);
    check("reset_ready", ready, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    do_op("pos_3x5", 16'sd3, 16'sd5);
    do_op("mix_m7x6", -16'sd7, 16'sd6);
    do_op("mix_max_min", 16'sd32767, -16'sd32768);
    check("max_min_value", product, -64'sd1073709056);
    do_op("min_min", -16'sd32768, -16'sd32768);
    check("min_min_value", product, 64'sd1073741824);
    do_op("zero_m1", 16'sd0, -16'sd1);

    // Back-to-back random pairs, each launched in the first IDLE cycle.
    for (int i = 0; i < 10; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      do_op($sformatf("rand%0d", i), ra, rb);
    end

    // Start held high through BUSY: one pulse only, nothing queued.
    do_op("pre_hold", 16'sd11, 16'sd13);
    multiplicand = 16'sd9;
    multiplier   = -16'sd4;
    start        = 1'b1;
    pulses = 0;
    for (int k = 0; k <= W; k++) begin
      @(negedge clk);
      if (ready) pulses++;
    end
    start = 1'b0;
    check("held_start_product", product, -9 * 4);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ready) pulses++;
    end
    check("held_start_pulses", pulses, 1);
    prev_product = -36;

    // Reset five cycles into BUSY aborts the operation.
    multiplicand = 16'sd100;
    multiplier   = 16'sd100;
    start        = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 0; k < 5; k++) @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_product", product, 0);
    check("abort_ready", ready, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    pulses = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (ready) pulses++;
    end
    check("abort_no_pulse", pulses, 0);
    prev_product = '0;
    do_op("post_reset", 16'sd2, -16'sd3);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
